dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the 5-stage pipeline. It services the M-stage memory request: address, byte-lane read enables, byte-lane write enables and lane-aligned write data. It returns lane-aligned read data to the M-stage load decoder. It holds a word-addressed RAM and inserts a parameterised number of wait states, raising `stall` to the hazard unit until each access completes.

## Interface
Parameters:
- `DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `WAIT`, 1: wait states per access, 0..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address (the M-stage ALU result); bits [1:0] ignored.
- `ren`  in  4  byte-lane read enables.
- `wen`  in  4  byte-lane write enables.
- `wdata`  in  32  lane-aligned store data.
- `rdata`  out  32  full word read; the load decoder extracts lanes.
- `stall`  out  1  to the hazard unit; the M stage and all earlier stages hold while it is high.
- `err`  out  1  access out of range or illegal; valid in the completion cycle only.

## Operation
- A request exists in a cycle when `ren != 0` or `wen != 0`.
- Word index = `addr[log2(DEPTH)+1:2]`.
- The access is out of range when `addr[31:2] >= DEPTH`.
- Both `ren` and `wen` nonzero is illegal. The write is performed and `err` is asserted.
- Write: the word at the index is updated only in lanes i where `wen[i]=1`, with `wdata[8i+7:8i]`. Other lanes keep their contents.
- Out-of-range write: dropped. Out-of-range read: returns 0. Both raise `err`.
- FSM (`WAIT>0`): IDLE, BUSY, DONE.
  - IDLE with a request: counter loads `WAIT-1` and the FSM goes to BUSY. `stall` is high in this cycle.
  - BUSY: counter decrements each cycle. At count 0 the FSM goes to DONE. On that edge, `rdata` is captured from the RAM and the write is committed.
  - DONE: `stall` is low, `rdata` and `err` are valid, the pipeline advances. The FSM returns to IDLE unconditionally, so the same request is never accepted twice.
- `WAIT=0`: the FSM stays in IDLE and `stall` is always 0. `rdata` is a combinational RAM read. The write commits at the edge ending the request cycle.
- Abort: if the request drops to zero while in BUSY (M-stage flush), the FSM returns to IDLE next edge. No write is committed, `rdata` is unchanged and `err` stays 0.
- Address, enables and data are sampled at the commit edge. The pipeline holds them stable under `stall`.

## Timing
- `stall` = (IDLE & request & `WAIT>0`) | BUSY. It is combinational from the request inputs.
- Total access cycles = `WAIT+1`. `stall` is high for exactly `WAIT` of them.
- `rdata` (`WAIT>0`) is registered. It holds its last completed-read value until the next read completes; writes do not change it.
- `err` is combinational, asserted only in the DONE cycle (or the request cycle when `WAIT=0`).
- Back-to-back requests: the next request is accepted in the IDLE cycle right after DONE. There is no dead cycle beyond that.
- Reset values: state IDLE, counter 0, `rdata` 0, `stall` 0, `err` 0.
- RAM contents are not reset; the bench preloads them.
- Reset mid-access cancels the access; no write is committed.

## Structure
- Package `dmem_pkg` holds:
  - the FSM state encoding (IDLE/BUSY/DONE);
  - the counter width constant (4);
  - the lane-count constant (4).
- Sub-module `dmem_wait_ctrl`: the FSM, wait counter, `stall` and the commit/capture strobes.
- The top level holds the RAM array, the lane-merge write and the range check.

## Test plan
- `WAIT=2`: preload word 4 = 0x11223344. Read `addr`=0x10, `ren`=4'hF. Required: `stall` high for 2 cycles, `rdata`=0x11223344 in cycle 3, `err`=0.
- `WAIT=2`: store `addr`=0x12, `wen`=4'b1100, `wdata`=0xAABB0000 to word 4, then read word 4. Required: `rdata`=0xAABB3344.
- `WAIT=0`: eight back-to-back stores then reads at 0x0..0x1C, full lanes. Required: `stall` never asserts and each read returns its stored word in the request cycle.
- `WAIT=3`: with `DEPTH=1024`, read `addr`=0x00001000. Required: `rdata`=0 and `err`=1 in DONE only. Store to the same address: `err`=1 and no RAM word changes.
- `WAIT=3`: store to 0x20, drop `wen` to 0 after 1 cycle, then read 0x20. Required: the old contents are returned and the FSM is in IDLE the cycle after the drop.
- `WAIT=3`: pull `rst` low mid-store, then release it and read the same word. Required: `stall`/`rdata`/`err` are 0 immediately and the word is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// wait-counter width, lane count and the byte-lane merge used by stores.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    localparam int CNT_W = 4;
    localparam int LANES = 4;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0]      old_word,
        input logic [31:0]      new_word,
        input logic [LANES-1:0] lane_en
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_wait_ctrl.sv
// Wait-state sequencer: IDLE/BUSY/DONE FSM with a down-counter, producing the
// hazard-unit stall plus the commit (write/capture) and done (err valid) strobes.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int WAIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic stall,
    output logic commit,
    output logic done
);

    generate
        if (WAIT == 0) begin : g_nowait
            logic unused_s;
            assign unused_s = clk ^ rst_n;
            assign stall    = 1'b0;
            assign commit   = req;
            assign done     = req;
        end else begin : g_wait
            localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT - 1);
            localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
            localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

            dmem_state_e      state_r, state_nxt_s;
            logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
            logic             stall_s, commit_s, done_s;

            // state and wait-counter registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end else begin
                    state_r <= state_nxt_s;
                    cnt_r   <= cnt_nxt_s;
                end
            end

            // next state, counter and strobes; the access commits on the edge entering DONE
            always_comb begin
                state_nxt_s = state_r;
                cnt_nxt_s   = cnt_r;
                stall_s     = 1'b0;
                commit_s    = 1'b0;
                done_s      = 1'b0;
                case (state_r)
                    ST_IDLE: begin
                        if (req) begin
                            stall_s   = 1'b1;
                            cnt_nxt_s = CNT_LOAD;
                            if (CNT_LOAD == CNT_ZERO) begin
                                state_nxt_s = ST_DONE;
                                commit_s    = 1'b1;
                            end else begin
                                state_nxt_s = ST_BUSY;
                            end
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                    ST_BUSY: begin
                        stall_s = 1'b1;
                        // request vanished under stall: M-stage flush, abandon the access
                        if (!req) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            cnt_nxt_s = cnt_r - CNT_ONE;
                            if (cnt_r == CNT_ONE) begin
                                state_nxt_s = ST_DONE;
                                commit_s    = 1'b1;
                            end else begin
                                state_nxt_s = ST_BUSY;
                            end
                        end
                    end
                    ST_DONE: begin
                        done_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                endcase
            end

            assign stall  = stall_s;
            assign commit = commit_s;
            assign done   = done_s;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: word RAM with byte-lane stores, range and
// legality checking, and a configurable number of wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [LANES-1:0] ren,
    input  logic [LANES-1:0] wen,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             stall,
    output logic             err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem_r [DEPTH];
    logic [IDX_W-1:0] idx_s;
    logic             req_s, oor_s, illegal_s, commit_s, done_s;
    logic [31:0]      rd_word_s;
    logic             unused_addr_s;

    // gating with reset keeps stall low while reset is held, even with enables up
    assign req_s         = rst & ((|ren) | (|wen));
    assign idx_s         = addr[IDX_W+1:2];
    assign oor_s         = (addr[31:2] >= 30'(DEPTH));
    assign illegal_s     = (|ren) & (|wen);
    assign rd_word_s     = oor_s ? 32'h0000_0000 : mem_r[idx_s];
    assign err           = done_s & (oor_s | illegal_s);
    assign unused_addr_s = ^addr[1:0];

    dmem_wait_ctrl #(
        .WAIT(WAIT)
    ) u_wait_ctrl (
        .clk   (clk),
        .rst_n (rst),
        .req   (req_s),
        .stall (stall),
        .commit(commit_s),
        .done  (done_s)
    );

    // RAM store: lane merge at the commit edge, out-of-range stores dropped
    always_ff @(posedge clk) begin
        if (commit_s && (|wen) && !oor_s) begin
            mem_r[idx_s] <= merge_lanes(mem_r[idx_s], wdata, wen);
        end
    end

    generate
        if (WAIT == 0) begin : g_comb_rd
            assign rdata = rd_word_s;
        end else begin : g_reg_rd
            logic [31:0] rdata_r;

            // read capture: only a pure read updates the returned word
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_r <= 32'h0000_0000;
                end else if (commit_s && (|ren) && !(|wen)) begin
                    rdata_r <= rd_word_s;
                end else begin
                    rdata_r <= rdata_r;
                end
            end

            assign rdata = rdata_r;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT=2, 0, 3) driven one
// at a time, with hand-computed expectations checked by immediate assertions.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: WAIT=2, instance 1: WAIT=0, instance 2: WAIT=3
    logic [2:0]        rst_v;
    logic [2:0][31:0]  addr_v, wdata_v, rdata_v;
    logic [2:0][3:0]   ren_v, wen_v;
    logic [2:0]        stall_v, err_v;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DEPTH(1024), .WAIT(2)) u_w2 (
        .clk(clk), .rst(rst_v[0]), .addr(addr_v[0]), .ren(ren_v[0]), .wen(wen_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .stall(stall_v[0]), .err(err_v[0])
    );

    dmem_responder #(.DEPTH(1024), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst_v[1]), .addr(addr_v[1]), .ren(ren_v[1]), .wen(wen_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .stall(stall_v[1]), .err(err_v[1])
    );

    dmem_responder #(.DEPTH(1024), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst_v[2]), .addr(addr_v[2]), .ren(ren_v[2]), .wen(wen_v[2]),
        .wdata(wdata_v[2]), .rdata(rdata_v[2]), .stall(stall_v[2]), .err(err_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // one complete access: w stall cycles then the completion cycle
    task automatic access(input int k, input int w, input logic [31:0] a,
                          input logic [3:0] re, input logic [3:0] we, input logic [31:0] wd,
                          input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                          input string tag);
        addr_v[k]  = a;
        ren_v[k]   = re;
        wen_v[k]   = we;
        wdata_v[k] = wd;
        for (int c = 0; c < w; c++) begin
            @(negedge clk);
            check({tag, "/stall"}, 32'(stall_v[k]), 32'h1);
            check({tag, "/err_early"}, 32'(err_v[k]), 32'h0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({tag, "/stall_done"}, 32'(stall_v[k]), 32'h0);
        check({tag, "/err"}, 32'(err_v[k]), 32'(exp_err));
        if (chk_rd) begin
            check({tag, "/rdata"}, rdata_v[k], exp_rd);
        end
        @(posedge clk);
        #1;
        ren_v[k] = 4'h0;
        wen_v[k] = 4'h0;
    endtask

    function automatic logic [31:0] pat(input int i);
        return {8'hA5, 8'(i), 8'h5A, 8'(i * 3)};
    endfunction

    initial begin
        rst_v   = 3'b000;
        addr_v  = '0;
        wdata_v = '0;
        ren_v   = '0;
        wen_v   = '0;
        #2;
        check("rst_w2_stall", 32'(stall_v[0]), 32'h0);
        check("rst_w2_rdata", rdata_v[0], 32'h0);
        check("rst_w2_err", 32'(err_v[0]), 32'h0);
        check("rst_w3_stall", 32'(stall_v[2]), 32'h0);
        check("rst_w3_rdata", rdata_v[2], 32'h0);
        check("rst_w0_stall", 32'(stall_v[1]), 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_v = 3'b111;

        // WAIT=2: full read, partial store merge, illegal read+write
        access(0, 2, 32'h10, 4'h0, 4'hF, 32'h1122_3344, 1'b0, 1'b1, 32'h0, "w2_preload4");
        access(0, 2, 32'h14, 4'h0, 4'hF, 32'h5566_7788, 1'b0, 1'b0, 32'h0, "w2_preload5");
        access(0, 2, 32'h10, 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1122_3344, "w2_read");
        access(0, 2, 32'h12, 4'h0, 4'b1100, 32'hAABB_0000, 1'b0, 1'b1, 32'h1122_3344, "w2_pstore");
        access(0, 2, 32'h10, 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, 32'hAABB_3344, "w2_merge");
        access(0, 2, 32'h14, 4'hF, 4'b0001, 32'h0000_00EE, 1'b1, 1'b0, 32'h0, "w2_illegal");
        access(0, 2, 32'h14, 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, 32'h5566_77EE, "w2_after_illegal");

        // WAIT=0: back-to-back stores then reads, no stall ever
        for (int i = 0; i < 8; i++) begin
            access(1, 0, 32'(i * 4), 4'h0, 4'hF, pat(i), 1'b0, 1'b0, 32'h0, "w0_store");
        end
        for (int i = 0; i < 8; i++) begin
            access(1, 0, 32'(i * 4), 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, pat(i), "w0_read");
        end

        // WAIT=3: out-of-range read and store (0x1000 aliases word 0 in the index bits)
        access(2, 3, 32'h0, 4'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, "w3_preload0");
        access(2, 3, 32'h0, 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, "w3_read0");
        access(2, 3, 32'h1000, 4'hF, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0, "w3_oor_read");
        access(2, 3, 32'h1000, 4'h0, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, "w3_oor_store");
        access(2, 3, 32'h0, 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, "w3_word0_intact");

        // WAIT=3: abort a store by dropping wen in BUSY
        access(2, 3, 32'h20, 4'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 32'hCAFE_F00D, "w3_preload20");
        addr_v[2]  = 32'h20;
        wen_v[2]   = 4'hF;
        wdata_v[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("abort_req_stall", 32'(stall_v[2]), 32'h1);
        @(posedge clk);
        #1;
        wen_v[2] = 4'h0;
        @(negedge clk);
        check("abort_busy_stall", 32'(stall_v[2]), 32'h1);
        check("abort_busy_err", 32'(err_v[2]), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_idle_stall", 32'(stall_v[2]), 32'h0);
        check("abort_idle_err", 32'(err_v[2]), 32'h0);
        check("abort_rdata_hold", rdata_v[2], 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        access(2, 3, 32'h20, 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, "abort_old_word");

        // WAIT=3: reset in the middle of a store
        access(2, 3, 32'h24, 4'h0, 4'hF, 32'h600D_CAFE, 1'b0, 1'b0, 32'h0, "rst_preload24");
        access(2, 3, 32'h24, 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, 32'h600D_CAFE, "rst_read24");
        addr_v[2]  = 32'h24;
        wen_v[2]   = 4'hF;
        wdata_v[2] = 32'hFFFF_FFFF;
        @(negedge clk);
        check("midrst_req_stall", 32'(stall_v[2]), 32'h1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_v[2] = 1'b0;
        #1;
        check("midrst_stall", 32'(stall_v[2]), 32'h0);
        check("midrst_rdata", rdata_v[2], 32'h0);
        check("midrst_err", 32'(err_v[2]), 32'h0);
        @(posedge clk);
        #1;
        wen_v[2] = 4'h0;
        @(posedge clk);
        #1;
        rst_v[2] = 1'b1;
        access(2, 3, 32'h24, 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, 32'h600D_CAFE, "midrst_word_intact");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
